// File: rtl/change_dispenser.sv
// Change dispenser: pays a 5-bit change amount as greedy 10/5-unit coin pulses
// through a hopper handshake, with a fixed idle gap between coin commands.
module change_dispenser #(
    parameter int unsigned COIN_GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       change_valid,
    input  logic [4:0] change_amount,
    input  logic       hopper_ready,
    output logic       busy,
    output logic       coin10,
    output logic       coin5,
    output logic       done,
    output logic       short,
    output logic [2:0] residue
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LOAD = COIN_GAP[3:0];

    state_t     state_r;
    state_t     state_next_s;
    logic [4:0] remaining_r;
    logic [4:0] remaining_next_s;
    logic [3:0] gap_cnt_r;
    logic [3:0] gap_cnt_next_s;
    logic       coin10_next_s;
    logic       coin5_next_s;
    logic       accept_s;

    // Next-state, next-remaining and coin-command decode.
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        gap_cnt_next_s   = gap_cnt_r;
        coin10_next_s    = 1'b0;
        coin5_next_s     = 1'b0;
        accept_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (change_valid) begin
                    accept_s         = 1'b1;
                    remaining_next_s = change_amount;
                    if (change_amount < 5'd5) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ISSUE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (remaining_r < 5'd5) begin
                    // Unreachable by construction; bail out rather than pay a coin we cannot cover.
                    state_next_s = ST_DONE;
                end else if (hopper_ready) begin
                    if (remaining_r >= 5'd10) begin
                        coin10_next_s    = 1'b1;
                        remaining_next_s = remaining_r - 5'd10;
                    end else begin
                        coin5_next_s     = 1'b1;
                        remaining_next_s = remaining_r - 5'd5;
                    end
                    if (remaining_next_s < 5'd5) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s   = ST_GAP;
                        gap_cnt_next_s = GAP_LOAD;
                    end
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r <= 4'd1) begin
                    state_next_s   = ST_ISSUE;
                    gap_cnt_next_s = 4'd0;
                end else begin
                    state_next_s   = ST_GAP;
                    gap_cnt_next_s = gap_cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs; done and the residue flags land as DONE is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            remaining_r <= 5'd0;
            gap_cnt_r   <= 4'd0;
            busy        <= 1'b0;
            coin10      <= 1'b0;
            coin5       <= 1'b0;
            done        <= 1'b0;
            short       <= 1'b0;
            residue     <= 3'd0;
        end else begin
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
            gap_cnt_r   <= gap_cnt_next_s;
            busy        <= (state_next_s != ST_IDLE);
            coin10      <= coin10_next_s;
            coin5       <= coin5_next_s;
            done        <= (state_next_s == ST_DONE);
            if (state_next_s == ST_DONE) begin
                short   <= (remaining_next_s != 5'd0);
                residue <= remaining_next_s[2:0];
            end else if (accept_s) begin
                short   <= 1'b0;
                residue <= 3'd0;
            end else begin
                short   <= short;
                residue <= residue;
            end
        end
    end

endmodule
